// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the 16x oversampled UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_LAST  = 4'd9;
    localparam logic [3:0] SMP_END   = 4'd15;

    function automatic int calc_tick_div(input int clock_freq, input int baud_rate);
        return clock_freq / (baud_rate * 16);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick divider with synchronous phase restart
module uart_os_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 8N1 UART receiver, 16x oversampling, 3-sample majority vote
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = calc_tick_div(CLOCK_FREQ, BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx_os16: TICK_DIV must be at least 1");
    end
    if (OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_os16: OVERSAMPLE must be 16");
    end

    logic       sync1_q;
    logic       rx_s_q;
    rx_state_e  state_q, state_d;
    logic [3:0] smp_cnt_q, smp_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       tick;
    logic       tick_restart;
    logic       vote;
    logic       mid_tick;
    logic       end_tick;

    uart_os_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(tick_restart),
        .tick   (tick)
    );

    // Third sample is taken live on the SMP_LAST tick so the vote is usable that same cycle.
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign mid_tick = tick && (smp_cnt_q == SMP_LAST);
    assign end_tick = tick && (smp_cnt_q == SMP_END);

    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shreg_d      = shreg_q;
        rdata_d      = rdata_q;
        rvalid_d     = rvalid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        tick_restart = 1'b0;

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        if (state_q != IDLE && tick) begin
            smp_cnt_d = smp_cnt_q + 4'd1;
            if (smp_cnt_q == SMP_FIRST) samp_d[0] = rx_s_q;
            if (smp_cnt_q == SMP_MID)   samp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                smp_cnt_d = 4'd0;
                if (!rx_s_q) begin
                    state_d      = START;
                    tick_restart = 1'b1;
                end
            end
            START: begin
                if (mid_tick && vote) begin
                    state_d = IDLE;
                end else if (end_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (mid_tick) begin
                    shreg_d = {vote, shreg_q[7:1]};
                end
                if (end_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed.
                if (mid_tick) begin
                    state_d = IDLE;
                    if (!vote) begin
                        frame_err_d = 1'b1;
                    end else if (rvalid_q && !rready) begin
                        overrun_d = 1'b1;
                    end else begin
                        rdata_d  = shreg_q;
                        rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            smp_cnt_q   <= 4'd0;
            bit_idx_q   <= 3'd0;
            samp_q      <= 2'b00;
            shreg_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
